// File: rtl/black_box_fifo.sv
// black_box_fifo: registered-output valid/ready FIFO with occupancy count and zero-masked head data
module black_box_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_bits,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_bits,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic enq, deq;
  always_comb begin
    enq_ready = count != FULL;
    deq_valid = count != '0;
    enq = enq_valid && enq_ready;
    deq = deq_ready && deq_valid;
    deq_bits = deq_valid ? mem[rptr] : '0;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      if (enq != deq) count <= enq ? count + 1'b1 : count - 1'b1;
    end
  // storage is left unreset; the zero mask on deq_bits hides stale entries
  always_ff @(posedge clock)
    if (enq) mem[wptr] <= enq_bits;
endmodule

// File: tb/tb_black_box_fifo.sv
// tb_black_box_fifo: directed and randomized checks of black_box_fifo against a queue model
module tb_black_box_fifo;
  localparam int W = 32;
  localparam int D = 4;
  logic clock = 0, reset = 0, enq_valid = 0, deq_ready = 0;
  logic enq_ready, deq_valid;
  logic [W-1:0] enq_bits = '0, deq_bits;
  logic [$clog2(D):0] count;
  logic [W-1:0] q [$];
  int checks = 0, errors = 0;
  black_box_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_bits(enq_bits), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_bits(deq_bits), .count(count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_chk(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(q.size() != D));
    chk({tag, ".deq_valid"}, 64'(deq_valid), 64'(q.size() != 0));
    chk({tag, ".deq_bits"}, 64'(deq_bits), q.size() != 0 ? 64'(q[0]) : 64'd0);
  endtask
  task automatic step(input string tag);
    logic e, d;
    logic [W-1:0] b;
    e = enq_valid && q.size() < D;
    d = deq_ready && q.size() > 0;
    b = enq_bits;
    @(posedge clock);
    if (d) void'(q.pop_front());
    if (e) q.push_back(b);
    #1;
    model_chk(tag);
  endtask
  task automatic drive(input logic ev, input logic [W-1:0] eb, input logic dr);
    enq_valid = ev;
    enq_bits = eb;
    deq_ready = dr;
  endtask
  initial begin
    #1 model_chk("reset");
    #2 reset = 1;
    for (int i = 0; i < 10; i++) step("idle");
    for (int i = 1; i <= 4; i++) begin
      drive(1, W'(i), 0);
      step("fill");
    end
    chk("fill.count4", 64'(count), 64'd4);
    chk("fill.enq_ready0", 64'(enq_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, '0, 1);
      chk("drain.head", 64'(deq_bits), 64'(i));
      step("drain");
    end
    chk("drain.count0", 64'(count), 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1, W'(i), 1);
      if (i > 0) chk("stream.head", 64'(deq_bits), 64'(i - 1));
      step("stream");
      chk("stream.count1", 64'(count), 64'd1);
    end
    drive(0, '0, 1);
    step("stream.end");
    for (int i = 0; i < 4; i++) begin
      drive(1, W'($urandom), 0);
      step("full.fill");
    end
    drive(1, 32'hAA, 1);
    step("full.both");
    chk("full.both.count3", 64'(count), 64'd3);
    drive(1, 32'hAA, 0);
    step("full.retry");
    chk("full.retry.count4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1);
      if (i == 3) chk("full.tail_aa", 64'(deq_bits), 64'hAA);
      step("full.drain");
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, W'(32'hD0 + i), 0);
      step("wrap.enq");
      drive(0, '0, 1);
      chk("wrap.head", 64'(deq_bits), 64'(32'hD0 + i));
      step("wrap.deq");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, W'($urandom), 0);
      step("mid.fill");
    end
    drive(0, '0, 0);
    reset = 0;
    q.delete();
    #1 model_chk("mid.reset");
    chk("mid.reset.count0", 64'(count), 64'd0);
    #1 reset = 1;
    drive(1, 32'h55, 0);
    step("mid.enq55");
    chk("mid.head55", 64'(deq_bits), 64'h55);
    chk("mid.count1", 64'(count), 64'd1);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), W'($urandom), 1'($urandom));
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/black_box_fifo.md
BLACK_BOX_FIFO -- requirements
Module: black_box_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width in bits; legal range is 1..64.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of entries; it must be a power of two in the range 2..16.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 resets the block.
REQ-005 The module SHALL have port enq_valid, input, 1 bit: the producer offers enq_bits.
REQ-006 The module SHALL have port enq_ready, output, 1 bit: the FIFO can accept an entry this cycle.
REQ-007 The module SHALL have port enq_bits, input, WIDTH bits: the write data.
REQ-008 The module SHALL have port deq_valid, output, 1 bit: the head entry is presented on deq_bits.
REQ-009 The module SHALL have port deq_ready, input, 1 bit: the consumer takes the head this cycle.
REQ-010 The module SHALL have port deq_bits, output, WIDTH bits: the head entry data.
REQ-011 The module SHALL have port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 An enqueue SHALL occur on a rising edge exactly when enq_valid=1 and enq_ready=1 in that cycle.
REQ-013 A dequeue SHALL occur on a rising edge exactly when deq_valid=1 and deq_ready=1 in that cycle.
REQ-014 enq_ready SHALL equal (count != DEPTH) and SHALL be driven purely from registered state, with no combinational path from deq_ready.
REQ-015 deq_valid SHALL equal (count != 0) and SHALL be driven purely from registered state, with no combinational path from enq_valid.
REQ-016 Write-to-read latency SHALL be 1 cycle: an entry enqueued on edge N is visible on deq_bits, with deq_valid=1, after edge N; there is no same-cycle flow-through.
REQ-017 Ordering SHALL be strict FIFO: entries are dequeued in enqueue order with bit-exact data.
REQ-018 deq_bits SHALL show the head entry when deq_valid=1 and SHALL be all zeros when deq_valid=0.
REQ-019 Read and write pointers SHALL be clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 with no gap or skipped slot.
REQ-020 count SHALL change as follows on each edge:
- +1 for enqueue only
- -1 for dequeue only
- unchanged for both, or for neither
REQ-021 Simultaneous enqueue and dequeue when 0 < count < DEPTH SHALL both complete, leaving count unchanged.
REQ-022 When full (count=DEPTH): enq_ready=0, so only a dequeue can occur; the freed slot is accepted no earlier than the next cycle.
REQ-023 When empty (count=0): deq_valid=0, so only an enqueue can occur; deq_ready is ignored.
REQ-024 enq_valid while enq_ready=0 SHALL have no effect on state; the producer holds its data.
REQ-025 The handshake SHALL follow valid/ready rules: once deq_valid=1, deq_valid and deq_bits stay stable until a dequeue occurs.

Reset
REQ-026 While reset=0, the following SHALL hold immediately, independent of clock:
- read and write pointers = 0
- count = 0
- enq_ready = 1
- deq_valid = 0
- deq_bits = 0
REQ-027 Storage contents need not be reset; stale data SHALL never appear on deq_bits because of REQ-018.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion behaves as from empty.
REQ-029 Deassertion of reset is assumed synchronized to clock externally; no internal synchronizer SHALL be included.

Verification
REQ-030 Reset then idle: deq_valid=0, enq_ready=1, count=0 and deq_bits=0 for 10 cycles.
REQ-031 Fill and drain (WIDTH=32, DEPTH=4):
- enqueue 0x1, 0x2, 0x3, 0x4 on back-to-back cycles with deq_ready=0 -> count=4, enq_ready=0
- then deq_ready=1 -> 0x1..0x4 dequeued on four consecutive edges, count returns to 0
REQ-032 Streaming: enq_valid=1 and deq_ready=1 held for 20 cycles with data 0..19 -> after the 1-cycle latency, deq_bits sequence is 0..19 with no gaps and count stays at 1.
REQ-033 Full with both requests: at count=4, assert enq_valid=1 (0xAA) and deq_ready=1 -> head dequeued, 0xAA not accepted that edge, count=3; 0xAA accepted on the following edge, count=4.
REQ-034 Wrap-around: 10 alternating single enqueue/dequeue pairs (data 0xD0..0xD9) -> all data exact and in order across two pointer wraps.
REQ-035 Mid-operation reset: with count=3, pulse reset=0 between clock edges -> count=0 and deq_valid=0 immediately; a subsequent enqueue of 0x55 appears alone at the head.
